// File: rtl/trng_ctrl.sv
// -----------------------------------------------------------------------------
// trng_ctrl
//
// Sequences an external random-number generator and hands its output words
// to two requesters.
//
// After reset, and whenever a new seed is loaded, the block:
//    1. drives put_seed for two cycles (SEED),
//    2. throws away WARMUP cycles of generator output (WARMUP),
//    3. delivers words from the generator to the requesters (RUN).
// In RUN, a round-robin arbiter delivers at most one word per cycle.
// After RESEED_INTERVAL delivered words, the generator is reseeded from its own
// output.
//
// Ports
//    clk       in   clock; every state change happens on the rising edge
//    rst       in   synchronous reset, active high
//    seed_we   in   one-cycle strobe: load seed_cfg and restart seeding
//    seed_cfg  in   [15:0] software seed, sampled while seed_we=1
//    rn_in     in   [15:0] output word from the generator
//    put_seed  out  seed-load control to the generator (state==SEED)
//    seed      out  [15:0] seed value to the generator
//    req       in   [1:0] request level per requester, held until served
//    gnt       out  [1:0] one-hot grant, one-cycle pulse per delivered word
//    rn_out    out  [15:0] delivered word, valid while rn_valid=1
//    rn_valid  out  word-delivery strobe, coincides with gnt
//    ready     out  high only in RUN
// -----------------------------------------------------------------------------
module trng_ctrl #(
   parameter int          WARMUP          = 16,
   parameter int          RESEED_INTERVAL = 1024,
   parameter logic [15:0] SEED_DEFAULT    = 16'd1327
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_we,
   input  logic [15:0] seed_cfg,
   input  logic [15:0] rn_in,
   output logic        put_seed,
   output logic [15:0] seed,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   output logic [15:0] rn_out,
   output logic        rn_valid,
   output logic        ready
);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   state_t      state_reg,    state_next;
   logic [15:0] cyc_reg,      cyc_next;     // counts cycles in SEED and WARMUP
   logic [15:0] word_reg,     word_next;    // words delivered since last seeding
   logic [15:0] seed_reg,     seed_next;
   logic [1:0]  gnt_reg,      gnt_next;
   logic        valid_reg,    valid_next;
   logic [15:0] rn_out_reg,   rn_out_next;
   logic        last_reg,     last_next;    // index of the last granted requester

   logic [1:0]  win;
   logic [15:0] word_inc;

   // A zero seed would lock up the generator, so it is replaced by the default.
   function automatic logic [15:0] fix_seed(input logic [15:0] v);
      return (v == 16'd0) ? SEED_DEFAULT : v;
   endfunction

   // Round robin: when both requesters are active, the one not granted last
   // wins. A single active requester always wins.
   always_comb begin
      if (req == 2'b11) begin
         win = last_reg ? 2'b01 : 2'b10;
      end else begin
         win = req;
      end
   end

   assign word_inc = word_reg + 16'd1;

   always_comb begin
      state_next  = state_reg;
      cyc_next    = cyc_reg;
      word_next   = word_reg;
      seed_next   = seed_reg;
      gnt_next    = 2'b00;
      valid_next  = 1'b0;
      rn_out_next = rn_out_reg;
      last_next   = last_reg;

      if (seed_we) begin
         // A software seed overrides everything except reset. No grant is
         // issued at this edge.
         state_next = ST_SEED;
         cyc_next   = 16'd0;
         word_next  = 16'd0;
         seed_next  = fix_seed(seed_cfg);
      end else begin
         case (state_reg)
            ST_SEED: begin
               if (cyc_reg == 16'd1) begin
                  state_next = ST_WARMUP;
                  cyc_next   = 16'd0;
               end else begin
                  cyc_next = cyc_reg + 16'd1;
               end
            end
            ST_WARMUP: begin
               if (cyc_reg == 16'(WARMUP - 1)) begin
                  state_next = ST_RUN;
                  cyc_next   = 16'd0;
               end else begin
                  cyc_next = cyc_reg + 16'd1;
               end
            end
            ST_RUN: begin
               if (req != 2'b00) begin
                  gnt_next    = win;
                  valid_next  = 1'b1;
                  rn_out_next = rn_in;
                  last_next   = win[1];
                  // The grant that reaches the interval is still delivered.
                  // The same sample also becomes the next seed.
                  if (word_inc == 16'(RESEED_INTERVAL)) begin
                     state_next = ST_SEED;
                     cyc_next   = 16'd0;
                     word_next  = 16'd0;
                     seed_next  = fix_seed(rn_in);
                  end else begin
                     word_next = word_inc;
                  end
               end
            end
            default: begin
               state_next = ST_SEED;
               cyc_next   = 16'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_SEED;
         cyc_reg    <= 16'd0;
         word_reg   <= 16'd0;
         seed_reg   <= SEED_DEFAULT;
         gnt_reg    <= 2'b00;
         valid_reg  <= 1'b0;
         rn_out_reg <= 16'd0;
         last_reg   <= 1'b1;
      end else begin
         state_reg  <= state_next;
         cyc_reg    <= cyc_next;
         word_reg   <= word_next;
         seed_reg   <= seed_next;
         gnt_reg    <= gnt_next;
         valid_reg  <= valid_next;
         rn_out_reg <= rn_out_next;
         last_reg   <= last_next;
      end
   end

   assign put_seed = (state_reg == ST_SEED);
   assign ready    = (state_reg == ST_RUN);
   assign seed     = seed_reg;
   assign gnt      = gnt_reg;
   assign rn_valid = valid_reg;
   assign rn_out   = rn_out_reg;

endmodule

// File: tb/tb_trng_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trng_ctrl
//
// Directed testbench for trng_ctrl, built with WARMUP=16 and RESEED_INTERVAL=8.
// Each clock step advances one rising edge. Outputs are sampled 1 time unit
// after that edge. Generator words change every cycle and are never zero,
// except where the test forces them to zero on purpose.
// -----------------------------------------------------------------------------
module tb_trng_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_we;
   logic [15:0] seed_cfg;
   logic [15:0] rn_in;
   logic        put_seed;
   logic [15:0] seed;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [15:0] rn_out;
   logic        rn_valid;
   logic        ready;

   int          checks   = 0;
   int          failures = 0;
   int          tcyc     = 0;
   logic [15:0] prev_rn;
   logic [15:0] exp_seed;

   trng_ctrl #(
      .WARMUP          (16),
      .RESEED_INTERVAL (8),
      .SEED_DEFAULT    (16'd1327)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seed_we  (seed_we),
      .seed_cfg (seed_cfg),
      .rn_in    (rn_in),
      .put_seed (put_seed),
      .seed     (seed),
      .req      (req),
      .gnt      (gnt),
      .rn_out   (rn_out),
      .rn_valid (rn_valid),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, tcyc);
      end
   endtask

   // Advance one edge. Remember the generator word that was present at the
   // edge, then present a fresh nonzero word for the next one.
   task automatic step();
      prev_rn = rn_in;
      @(posedge clk);
      #1;
      tcyc++;
      rn_in = {tcyc[7:0], 8'h5A};
   endtask

   // Call this while the first SEED cycle is visible. It walks through
   // 2 SEED cycles and 16 WARMUP cycles, and finishes with the first RUN cycle
   // visible.
   task automatic seed_phase(input string tag, input logic [15:0] s);
      check({tag, "_seed0_put"}, put_seed, 1);
      check({tag, "_seed0_val"}, seed, s);
      check({tag, "_seed0_rdy"}, ready, 0);
      step();
      check({tag, "_seed1_put"}, put_seed, 1);
      check({tag, "_seed1_gnt"}, gnt, 2'b00);
      for (int i = 0; i < 16; i++) begin
         step();
         check({tag, "_warm_put"}, put_seed, 0);
         check({tag, "_warm_rdy"}, ready, 0);
         check({tag, "_warm_gnt"}, {rn_valid, gnt}, 3'b000);
      end
      step();
      check({tag, "_run_rdy"}, ready, 1);
      check({tag, "_run_gnt"}, gnt, 2'b00);
      $display("seed phase %s done, seed=%0h, ready at cycle %0d", tag, s, tcyc);
   endtask

   task automatic grant_step(input string tag, input logic [1:0] g);
      step();
      check({tag, "_gnt"}, gnt, g);
      check({tag, "_vld"}, rn_valid, 1);
      check({tag, "_word"}, rn_out, prev_rn);
      $display("grant %s gnt=%b rn_out=%h", tag, gnt, rn_out);
   endtask

   initial begin
      rst      = 1'b1;
      seed_we  = 1'b0;
      seed_cfg = 16'd0;
      req      = 2'b00;
      rn_in    = 16'h005A;
      prev_rn  = 16'h0;

      // Reset values
      step();
      step();
      check("rst_gnt", gnt, 2'b00);
      check("rst_vld", rn_valid, 0);
      check("rst_rnout", rn_out, 16'h0);
      check("rst_seed", seed, 16'd1327);
      check("rst_put", put_seed, 1);
      check("rst_rdy", ready, 0);
      rst = 1'b0;
      seed_phase("boot", 16'd1327);

      // Both requesters hold their request: grants alternate, requester 0
      // first.
      req = 2'b11;
      for (int i = 0; i < 6; i++) grant_step("rr11", (i % 2 == 0) ? 2'b01 : 2'b10);
      req = 2'b00;
      step();
      check("idle_gnt", {rn_valid, gnt}, 3'b000);

      // A zero seed from software becomes 1327, and no grant is issued at that
      // edge.
      req      = 2'b11;
      seed_we  = 1'b1;
      seed_cfg = 16'h0000;
      step();
      seed_we = 1'b0;
      check("swz_nogrant", {rn_valid, gnt}, 3'b000);
      seed_phase("swzero", 16'd1327);
      req = 2'b00;

      // Only requester 1 requests, then both: requester 0 is next.
      step();
      req = 2'b10;
      for (int i = 0; i < 4; i++) grant_step("only10", 2'b10);
      req = 2'b11;
      grant_step("after10", 2'b01);
      req = 2'b00;
      step();
      check("idle2_gnt", {rn_valid, gnt}, 3'b000);

      // Load seed 16'hBEEF from software.
      seed_we  = 1'b1;
      seed_cfg = 16'hBEEF;
      step();
      seed_we = 1'b0;
      seed_phase("beef", 16'hBEEF);

      // Reseed after 8 words: the 8th word also becomes the new seed.
      req = 2'b01;
      for (int i = 0; i < 8; i++) grant_step("ivl", 2'b01);
      exp_seed = prev_rn;
      check("ivl_rdy", ready, 0);
      seed_phase("ivl", exp_seed);
      grant_step("resume", 2'b01);
      for (int i = 0; i < 6; i++) grant_step("ivl2", 2'b01);
      rn_in = 16'h0000;  // the 8th word is zero, so the seed falls back to 1327
      grant_step("ivl2z", 2'b01);
      check("ivl2z_seed", seed, 16'd1327);
      check("ivl2z_put", put_seed, 1);

      // Reset pulse in WARMUP cycle 5 while both requesters are active.
      req = 2'b11;
      step();  // SEED cycle 1
      for (int i = 0; i < 6; i++) step();  // WARMUP cycles 0..5
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_gnt", {rn_valid, gnt}, 3'b000);
      check("mrst_rnout", rn_out, 16'h0);
      seed_phase("mrst", 16'd1327);
      grant_step("mrst_first", 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trng_ctrl.md
TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 Parameter WARMUP, 16, number of post-seed cycles whose generator output is discarded.
REQ-002 Parameter RESEED_INTERVAL, 1024, number of delivered words after which the generator is automatically reseeded.
REQ-003 Parameter SEED_DEFAULT, 16'd1327, seed used after reset and whenever a zero seed would be loaded.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 seed_we  in  1  one-cycle strobe; load seed_cfg and restart seeding.
REQ-007 seed_cfg  in  16  software seed value, sampled when seed_we=1.
REQ-008 rn_in  in  16  generator output word (the generator's out port).
REQ-009 put_seed  out  1  seed-load control to the generator.
REQ-010 seed  out  16  seed value to the generator.
REQ-011 req  in  2  per-requester request; level, held until served.
REQ-012 gnt  out  2  one-hot grant, one-cycle pulse per delivered word.
REQ-013 rn_out  out  16  delivered random word, valid when rn_valid=1.
REQ-014 rn_valid  out  1  word-delivery strobe, coincident with gnt.
REQ-015 ready  out  1  high only while in RUN.

Function
REQ-016 FSM states SEED, WARMUP, RUN; put_seed SHALL equal (state==SEED) and ready SHALL equal (state==RUN), both decoded from the state register.
REQ-017 SEED SHALL last exactly 2 cycles (cycle counter 0..1), then go to WARMUP with the counter cleared.
REQ-018 WARMUP SHALL last exactly WARMUP cycles; no grants are issued; then go to RUN.
REQ-019 In RUN, at each edge with req!=0, the block SHALL register gnt (one-hot), rn_valid=1 and rn_out=rn_in sampled at that edge; if req==0, gnt=0 and rn_valid=0 at the next cycle.
REQ-020 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with a single request, that requester wins; the last-granted pointer updates only on a grant.
REQ-021 At most one word SHALL be delivered per cycle; each generator sample SHALL be delivered at most once.
REQ-022 A 16-bit delivered-word counter SHALL increment per grant; the grant that brings it to RESEED_INTERVAL SHALL also move the state to SEED, load seed<=rn_in at that edge, and clear the counter.
REQ-023 seed_we=1 at any state SHALL move to SEED at that edge, load seed<=seed_cfg, clear all counters, and issue no grant at that edge; seed_we during SEED restarts the 2-cycle count.
REQ-024 Any seed value of 0 (from seed_cfg or rn_in) SHALL be replaced by SEED_DEFAULT.
REQ-025 Priority per edge: rst > seed_we > interval reseed > grant.
REQ-026 gnt and rn_valid SHALL be 0 in every cycle where the registered state at the previous edge was not RUN.

Reset
REQ-027 While rst=1 at an edge: state<=SEED, cycle counter<=0, word counter<=0, seed<=SEED_DEFAULT, gnt<=0, rn_valid<=0, rn_out<=0, last-granted pointer<=1 (requester 0 wins first).
REQ-028 Reset asserted mid-WARMUP or mid-RUN SHALL abort the operation with no further grants; seeding restarts after deassertion.

Verification
REQ-029 Release rst, req=00 -> put_seed=1 and seed=1327 for 2 cycles, then put_seed=0, ready=1 exactly 16 cycles later, gnt stays 00.
REQ-030 RUN, req=11 held 6 cycles -> gnt=01,10,01,10,01,10; rn_valid=1 each cycle; rn_out equals rn_in from the preceding edge.
REQ-031 RUN, req=10 held 4 cycles -> gnt=10 every cycle; then req=11 -> next gnt=01.
REQ-032 RESEED_INTERVAL=8, req=01 held -> 8 grants, then ready=0, put_seed=1 for 2 cycles with seed=rn_in captured at the 8th grant edge, 16 idle cycles, grants resume.
REQ-033 RUN, seed_we=1 with seed_cfg=0 -> no grant at that edge, seed=1327, put_seed=1 next 2 cycles; seed_cfg=16'hBEEF likewise loads 16'hBEEF.
REQ-034 rst pulse at WARMUP cycle 5 with req=11 -> gnt=00, rn_valid=0, rn_out=0; full 2+16 sequence repeats before the first grant to requester 0.
